// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 round sequencer: round count, datapath mode codes and FSM states.
package aes_pkg;

    localparam int unsigned AES_NR = 10;
    localparam int unsigned AES_RW = 4;
    localparam int unsigned AES_BW = 128;

    typedef enum logic [1:0] {
        MODE_ARK_ONLY = 2'b00,
        MODE_FULL     = 2'b01,
        MODE_FINAL    = 2'b10
    } dp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// AES-128 round-loop controller around one shared round datapath; results are fed back until round NR.
// Define AES_BLK_CNT_EN to add the blk_cnt completed-block counter port.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned RW = AES_RW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AES_BW-1:0] in_block,
    output logic [RW-1:0]     key_idx,
    input  logic [AES_BW-1:0] round_key,
    output logic              dp_valid,
    output logic [AES_BW-1:0] dp_state,
    output logic [AES_BW-1:0] dp_key,
    output logic [RW-1:0]     dp_round,
    output logic [1:0]        dp_mode,
    input  logic              dp_out_valid,
    input  logic [AES_BW-1:0] dp_out_state,
    output logic              out_valid,
    output logic [AES_BW-1:0] out_block,
`ifdef AES_BLK_CNT_EN
    output logic [31:0]       blk_cnt,
`endif
    input  logic              out_ready
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    seq_state_e        fsm_q;
    seq_state_e        fsm_d;
    logic [AES_BW-1:0] state_q;
    logic [AES_BW-1:0] state_d;
    logic [RW-1:0]     round_q;
    logic [RW-1:0]     round_d;
    logic              in_ready_d;
    logic              dp_valid_d;
    logic              out_valid_d;
    dp_mode_e          mode_d;

    // Next-state, round counter and next-cycle output decode
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_d     = round_q;
        in_ready_d  = 1'b0;
        dp_valid_d  = 1'b0;
        out_valid_d = 1'b0;
        mode_d      = MODE_FULL;

        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = in_block;
                    round_d = '0;
                    fsm_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fsm_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Results arriving in any other state belong to nobody and are dropped
                if (dp_out_valid) begin
                    state_d = dp_out_state;
                    if (round_q == LAST_ROUND) begin
                        fsm_d = ST_DONE;
                    end else begin
                        round_d = round_q + RW'(1);
                        fsm_d   = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (fsm_d == ST_IDLE);
        dp_valid_d  = (fsm_d == ST_ISSUE);
        out_valid_d = (fsm_d == ST_DONE);

        if (round_d == '0) begin
            mode_d = MODE_ARK_ONLY;
        end else if (round_d == LAST_ROUND) begin
            mode_d = MODE_FINAL;
        end else begin
            mode_d = MODE_FULL;
        end
    end

    // State and registered outputs; issue and result fields hold between loads
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= ST_IDLE;
            state_q   <= '0;
            round_q   <= '0;
            in_ready  <= 1'b1;
            dp_valid  <= 1'b0;
            out_valid <= 1'b0;
            dp_state  <= '0;
            dp_round  <= '0;
            dp_mode   <= MODE_ARK_ONLY;
            out_block <= '0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            round_q   <= round_d;
            in_ready  <= in_ready_d;
            dp_valid  <= dp_valid_d;
            out_valid <= out_valid_d;
            if (dp_valid_d) begin
                dp_state <= state_d;
                dp_round <= round_d;
                dp_mode  <= mode_d;
            end
            if (out_valid_d) begin
                out_block <= state_d;
            end
        end
    end

    assign key_idx = dp_round;
    assign dp_key  = round_key;

`ifdef AES_BLK_CNT_EN
    // Completed-block counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
